// File: rtl/rom_loader_responder_if.sv
// Handshake bundles for the ROM loader: the initiator-to-responder word channel
// and the req/ready ROM write port.

interface rom_loader_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  rom_loader_reset;
  logic                  rom_loader_load;
  logic [DATA_WIDTH-1:0] rom_loader_data;
  logic                  rom_loader_load_received;
  logic                  rom_loader_ack;

  modport master (
    output rom_loader_reset,
    output rom_loader_load,
    output rom_loader_data,
    input  rom_loader_load_received,
    input  rom_loader_ack
  );

  modport slave (
    input  rom_loader_reset,
    input  rom_loader_load,
    input  rom_loader_data,
    output rom_loader_load_received,
    output rom_loader_ack
  );
endinterface

interface rom_write_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 15
);
  logic                  mem_write_req;
  logic [ADDR_WIDTH-1:0] mem_write_addr;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  mem_write_ready;

  modport master (
    output mem_write_req,
    output mem_write_addr,
    output mem_write_data,
    input  mem_write_ready
  );

  modport slave (
    input  mem_write_req,
    input  mem_write_addr,
    input  mem_write_data,
    output mem_write_ready
  );
endinterface

// File: rtl/rom_loader_responder.sv
// Responder side of the ROM-loader handshake: takes one word per handshake and
// writes words sequentially from address 0 into the instruction ROM.

module rom_loader_responder #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  rom_loader_if.slave       loader,
  rom_write_if.master       mem,
  output logic [ADDR_WIDTH:0] words_written,
  output logic              overflow,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_load_received;
  logic                  r_ack;
  logic                  r_req;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ADDR_WIDTH:0]   r_words_written;
  logic                  r_overflow;
  logic                  r_busy;
  logic                  w_full;

  // The counter never exceeds ROM_DEPTH, so its top bit alone marks a full ROM.
  assign w_full = r_words_written[ADDR_WIDTH];

  // An ACK entry with load_received still high is the overflow path: the
  // discarded word still owes its ack pulse before returning to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= IDLE;
      r_load_received <= 1'b0;
      r_ack           <= 1'b0;
      r_req           <= 1'b0;
      r_addr          <= '0;
      r_data          <= '0;
      r_words_written <= '0;
      r_overflow      <= 1'b0;
      r_busy          <= 1'b0;
    end else if (loader.rom_loader_reset) begin
      r_state         <= IDLE;
      r_load_received <= 1'b0;
      r_ack           <= 1'b0;
      r_req           <= 1'b0;
      r_addr          <= '0;
      r_data          <= '0;
      r_words_written <= '0;
      r_overflow      <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (loader.rom_loader_load) begin
            r_load_received <= 1'b1;
            r_busy          <= 1'b1;
            if (!w_full) begin
              r_data  <= loader.rom_loader_data;
              r_addr  <= r_words_written[ADDR_WIDTH-1:0];
              r_req   <= 1'b1;
              r_state <= WRITE;
            end else begin
              r_overflow <= 1'b1;
              r_state    <= ACK;
            end
          end
        end
        WRITE: begin
          r_load_received <= 1'b0;
          if (mem.mem_write_ready) begin
            r_req           <= 1'b0;
            r_words_written <= r_words_written + (ADDR_WIDTH+1)'(1);
            r_ack           <= 1'b1;
            r_state         <= ACK;
          end
        end
        ACK: begin
          if (r_load_received) begin
            r_load_received <= 1'b0;
            r_ack           <= 1'b1;
          end else begin
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state         <= IDLE;
          r_load_received <= 1'b0;
          r_ack           <= 1'b0;
          r_req           <= 1'b0;
          r_busy          <= 1'b0;
        end
      endcase
    end
  end

  assign loader.rom_loader_load_received = r_load_received;
  assign loader.rom_loader_ack           = r_ack;
  assign mem.mem_write_req               = r_req;
  assign mem.mem_write_addr              = r_addr;
  assign mem.mem_write_data              = r_data;
  assign words_written                   = r_words_written;
  assign overflow                        = r_overflow;
  assign busy                            = r_busy;

endmodule

// File: doc/rom_loader_responder.md
Name: rom_loader_responder

Overview:
- Responder end of the ROM-loader handshake: accepts one word at a time from a loader initiator (pattern source, SPI/UART bridge) over rom_loader_reset/load/data.
- Returns rom_loader_load_received and rom_loader_ack.
- Writes each word sequentially from address 0 into the Hack instruction ROM through a req/ready write port.
- Sits between the loader initiator and the ROM write port; busy is used to hold the CPU in reset while loading.

Parameters:
DATA_WIDTH, 16, width of a ROM word
ADDR_WIDTH, 15, ROM address width; ROM_DEPTH = 2**ADDR_WIDTH words

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
rom_loader_reset  input  1  synchronous restart from initiator
rom_loader_load  input  1  initiator has a valid word on rom_loader_data
rom_loader_data  input  DATA_WIDTH  word to store
rom_loader_load_received  output  1  one-cycle pulse: word captured, initiator may present next word
rom_loader_ack  output  1  one-cycle pulse: word committed to ROM (or discarded on overflow)
mem_write_req  output  1  write request to ROM port
mem_write_addr  output  ADDR_WIDTH  write address
mem_write_data  output  DATA_WIDTH  write data
mem_write_ready  input  1  ROM port accepts write when high with req
words_written  output  ADDR_WIDTH+1  count of words committed since last restart
overflow  output  1  sticky: a word arrived with ROM full
busy  output  1  high whenever state != IDLE

Behaviour:
- All outputs are registered. reset_n low (async) forces:
  - state IDLE
  - all pulses, mem_write_req, overflow and busy = 0
  - mem_write_addr = 0, mem_write_data = 0, words_written = 0
- States: IDLE, WRITE, ACK.
- rom_loader_reset = 1 at an edge has highest priority, in any state:
  - same effect as reset_n, except synchronous
  - rom_loader_load is ignored in that cycle
  - an in-flight write is aborted: req drops, no ack is issued
- IDLE, rom_loader_load = 1 sampled:
  - If words_written < ROM_DEPTH: latch rom_loader_data into mem_write_data, drive mem_write_addr = words_written[ADDR_WIDTH-1:0], set mem_write_req = 1, set rom_loader_load_received = 1, go to WRITE.
  - If words_written == ROM_DEPTH: set overflow = 1, pulse load_received, go to ACK; no write, counter unchanged.
- IDLE, rom_loader_load = 0: stay in IDLE.
- WRITE:
  - load_received clears after exactly one cycle.
  - mem_write_req, addr and data are held stable until mem_write_ready = 1 is sampled.
  - On that edge: req <= 0, words_written += 1, rom_loader_ack <= 1, go to ACK.
  - rom_loader_load/data are not sampled in WRITE; the initiator changes them freely after load_received.
- ACK: ack clears after one cycle; go to IDLE. The next word is sampled in IDLE at the following edge.
- Latency with ready tied high, load sampled at edge E0:
  - load_received and req high during E0..E1
  - write at E1; ack high during E1..E2
  - IDLE from E2; next sample at E3
  - 3 cycles per word
- load_received and ack are never high in the same cycle. Each accepted word produces exactly one of each, in that order.
- Address arithmetic:
  - no wrap: the last writable address is ROM_DEPTH-1, after which words_written = ROM_DEPTH
  - further words are acked and discarded, and overflow stays set until restart

Test Plan:
- Single word, ready tied high: reset_n pulse, then load = 1, data = 16'hEA87 -> mem_write_req at addr 0 with data EA87 for 1 cycle; load_received one cycle before ack; words_written = 1; busy high for exactly 3 cycles.
- Stalled ROM: ready held low for 5 cycles -> req/addr/data stable for 6 cycles, no ack until ready; exactly one write; ack the cycle after ready is sampled.
- Back-to-back against an initiator model sending 4 words (0000, EA87, FFFF, 0000), starting with rom_loader_reset+load together:
  - writes land at addr 0..3 with the correct data
  - 4 load_received and 4 ack pulses
  - initiator sees ack with no words left and asserts done
- Overflow with ADDR_WIDTH = 2, 5 words sent -> addr 0..3 written; 5th word gets load_received and ack, no mem_write_req; overflow = 1, words_written = 4.
- rom_loader_reset asserted while in WRITE with ready low -> next cycle req = 0, no ack, words_written = 0, overflow cleared; a following word is written to addr 0.
- Asynchronous reset_n asserted mid-cycle during ACK -> all outputs zero immediately without a clock edge; after release the block stays idle until load.
